writeback_stage: RTL

//  Stage-5 write side of the register file: holds the MEM/WB pipeline register, selects the result and

---
 rtl/pipeline_pkg.sv | 43 ++++
 rtl/wb_scoreboard.sv | 107 ++++++++++
 rtl/writeback_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline write-back slice.
//   - Default widths for the data path, register index and retire counter.
//   - Result-select encodings used by the MEM/WB register.
//   - The pending-write scoreboard count type, its ceiling, and the
//     next-count helper used by every register's counter.
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_CNT_WIDTH  = 16;

   // Result select: ALU output or data-memory load value
   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   // Each register tracks at most three unretired writers
   typedef logic [1:0] sb_count_t;
   localparam sb_count_t SB_MAX = 2'd3;

   // Next value of one scoreboard counter. A simultaneous issue and retire
   // to the same register cancel out. The counter saturates at SB_MAX and
   // never wraps below zero; the caller flags the saturating case.
   function automatic sb_count_t sbNext(input sb_count_t count,
                                        input logic      inc,
                                        input logic      dec);
      sb_count_t result;
      result = count;
      if (inc && !dec) begin
         if (count != SB_MAX) begin
            result = count + 2'd1;
         end
      end else if (dec && !inc) begin
         if (count != 2'd0) begin
            result = count - 2'd1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Per-register count of issued-but-unretired writers. Decode uses the busy
// outputs to stall when a source operand still has an older writer in flight.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   flush_in          clears every count (an issue in that cycle is dropped)
//   issue_valid       decode issues a register-writing instruction
//   issue_dest        its destination register
//   write_enable      register file write this cycle (a writer retires)
//   write_address     register being written
//   dec_addr1/2       decode source register indices
//   src_busy1/2       source still has an older writer that is not retiring now
//   sb_overflow       sticky: an issue hit a counter already at its ceiling
// ---------------------------------------------------------------------------
module wb_scoreboard
   import pipeline_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_in,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_dest,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [ADDR_WIDTH-1:0] dec_addr1,
   input  logic [ADDR_WIDTH-1:0] dec_addr2,
   output logic                  src_busy1,
   output logic                  src_busy2,
   output logic                  sb_overflow
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   sb_count_t             r_count [NUM_REGS];
   logic                  r_overflow;
   logic [NUM_REGS-1:0]   w_inc;
   logic [NUM_REGS-1:0]   w_dec;
   logic [NUM_REGS-1:0]   w_sat;
   logic [NUM_REGS-1:0]   w_zero;
   logic                  w_underflow;
   sb_count_t             w_count1;
   sb_count_t             w_count2;

   // Decode the issue and retire events into one-hot per-register strobes,
   // and spot the two corner cases: an issue into a full counter (overflow)
   // and a retire from an empty one (should be impossible).
   always_comb begin
      w_inc  = '0;
      w_dec  = '0;
      w_sat  = '0;
      w_zero = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_inc[i]  = issue_valid  && (issue_dest    == ADDR_WIDTH'(i));
         w_dec[i]  = write_enable && (write_address == ADDR_WIDTH'(i));
         w_zero[i] = (r_count[i] == 2'd0);
         w_sat[i]  = w_inc[i] && !w_dec[i] && (r_count[i] == SB_MAX);
      end
      w_underflow = |(w_dec & ~w_inc & w_zero);
   end

   // Counter update. Flush wipes all pending writers but leaves the sticky
   // overflow flag alone so software can still see that it happened.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_count[i] <= 2'd0;
         end
         r_overflow <= 1'b0;
      end else if (flush_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_count[i] <= 2'd0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_count[i] <= sbNext(r_count[i], w_inc[i], w_dec[i]);
         end
         if (|w_sat) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // A retire from a register with no recorded writer means the pipeline
   // and the scoreboard have lost track of each other.
   always_ff @(posedge clk) begin
      if (!reset && !flush_in) begin
         assert (!w_underflow);
      end
   end

   // A source is busy while it has a pending writer, except when the last
   // one retires this very cycle: its value reaches decode via the bypass.
   always_comb begin
      w_count1  = r_count[dec_addr1];
      w_count2  = r_count[dec_addr2];
      src_busy1 = (w_count1 != 2'd0) &&
                  !(write_enable && (write_address == dec_addr1) && (w_count1 == 2'd1));
      src_busy2 = (w_count2 != 2'd0) &&
                  !(write_enable && (write_address == dec_addr2) && (w_count2 == 2'd1));
   end

   assign sb_overflow = r_overflow;

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Write side of the register file: the MEM/WB pipeline register, the result
// select, the register file write port, same-cycle bypass of that write onto
// the decode operands, the pending-write scoreboard and a retire counter.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   stall_in                    hold MEM/WB, suppress write and retire
//   flush_in                    kill the incoming entry, clear the scoreboard
//   mem_valid/mem_reg_write     incoming instruction and its write intent
//   mem_wb_sel                  result select (ALU or load)
//   mem_dest                    destination register
//   mem_alu_result/load_data    candidate results
//   issue_valid/issue_dest      decode issuing a register writer
//   dec_addr1/2, rf_data1/2     decode sources and raw file read data
//   rf_write_*                  register file write port
//   dec_data1/2                 bypass-corrected operands
//   src_busy1/2, sb_overflow    scoreboard hazard and sticky overflow
//   retired_count               wrapping count of retired instructions
// ---------------------------------------------------------------------------
module writeback_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_in,
   input  logic                  flush_in,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic                  mem_wb_sel,
   input  logic [ADDR_WIDTH-1:0] mem_dest,
   input  logic [DATA_WIDTH-1:0] mem_alu_result,
   input  logic [DATA_WIDTH-1:0] mem_load_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_dest,
   input  logic [ADDR_WIDTH-1:0] dec_addr1,
   input  logic [ADDR_WIDTH-1:0] dec_addr2,
   input  logic [DATA_WIDTH-1:0] rf_data1,
   input  logic [DATA_WIDTH-1:0] rf_data2,
   output logic                  rf_write_enable,
   output logic [ADDR_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic [DATA_WIDTH-1:0] dec_data1,
   output logic [DATA_WIDTH-1:0] dec_data2,
   output logic                  src_busy1,
   output logic                  src_busy2,
   output logic                  sb_overflow,
   output logic [CNT_WIDTH-1:0]  retired_count
);

   logic                  r_wbValid;
   logic                  r_wbRegWrite;
   logic                  r_wbSel;
   logic [ADDR_WIDTH-1:0] r_wbDest;
   logic [DATA_WIDTH-1:0] r_wbAlu;
   logic [DATA_WIDTH-1:0] r_wbLoad;
   logic [CNT_WIDTH-1:0]  r_retiredCount;

   logic                  w_writeEnable;
   logic [DATA_WIDTH-1:0] w_writeData;
   logic                  w_retire;

   // MEM/WB register. A stall freezes everything; a flush clears the valid
   // bit even while stalled so the held entry cannot retire later.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wbValid    <= 1'b0;
         r_wbRegWrite <= 1'b0;
         r_wbSel      <= WB_SEL_ALU;
         r_wbDest     <= '0;
         r_wbAlu      <= '0;
         r_wbLoad     <= '0;
      end else begin
         if (!stall_in) begin
            r_wbRegWrite <= mem_reg_write;
            r_wbSel      <= mem_wb_sel;
            r_wbDest     <= mem_dest;
            r_wbAlu      <= mem_alu_result;
            r_wbLoad     <= mem_load_data;
         end
         if (flush_in) begin
            r_wbValid <= 1'b0;
         end else if (!stall_in) begin
            r_wbValid <= mem_valid;
         end
      end
   end

   // Write port and bypass. The file writes at the clock edge but decode
   // reads it combinationally, so a write landing this cycle has to be
   // forwarded or decode would see the old contents.
   always_comb begin
      w_writeEnable = r_wbValid && r_wbRegWrite && !stall_in;
      w_writeData   = (r_wbSel == WB_SEL_MEM) ? r_wbLoad : r_wbAlu;
      w_retire      = r_wbValid && !stall_in;
      dec_data1     = (w_writeEnable && (r_wbDest == dec_addr1)) ? w_writeData : rf_data1;
      dec_data2     = (w_writeEnable && (r_wbDest == dec_addr2)) ? w_writeData : rf_data2;
   end

   // Retire counter: every valid entry leaving the stage counts, including
   // those that do not write a register. Wraps silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retiredCount <= '0;
      end else if (w_retire) begin
         r_retiredCount <= r_retiredCount + CNT_WIDTH'(1);
      end
   end

   wb_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .flush_in      (flush_in),
      .issue_valid   (issue_valid),
      .issue_dest    (issue_dest),
      .write_enable  (w_writeEnable),
      .write_address (r_wbDest),
      .dec_addr1     (dec_addr1),
      .dec_addr2     (dec_addr2),
      .src_busy1     (src_busy1),
      .src_busy2     (src_busy2),
      .sb_overflow   (sb_overflow)
   );

   assign rf_write_enable  = w_writeEnable;
   assign rf_write_address = r_wbDest;
   assign rf_write_data    = w_writeData;
   assign retired_count    = r_retiredCount;

endmodule
